// File: rtl/ff_conv_pkg.sv
// Shared definitions for the flip-flop conversion blocks: illegal-input
// policy codes, JK next-state and SR-to-JK conversion gating.
package ff_conv_pkg;

   // Policy applied when S=R=1 is presented to an SR bit
   localparam int unsigned MODE_HOLD    = 0;
   localparam int unsigned MODE_RST_DOM = 1;
   localparam int unsigned MODE_SET_DOM = 2;

   // J/K pair driven into a JK core
   typedef struct packed {
      logic j;
      logic k;
   } jk_t;

   // Map any unsupported policy code onto hold
   function automatic int unsigned norm_mode(input int unsigned mode);
      if ((mode == MODE_RST_DOM) || (mode == MODE_SET_DOM)) begin
         return mode;
      end
      return MODE_HOLD;
   endfunction

   // Standard JK next-state: hold, reset, set, toggle
   function automatic logic jk_next(input logic q, input logic j, input logic k);
      logic nxt;
      case ({j, k})
         2'b00:   nxt = q;
         2'b01:   nxt = 1'b0;
         2'b10:   nxt = 1'b1;
         default: nxt = ~q;
      endcase
      return nxt;
   endfunction

   // SR request to JK drive; S=R=1 is steered by policy so J=K=1 never occurs
   function automatic jk_t sr_gate(input int unsigned mode,
                                   input logic        s,
                                   input logic        r,
                                   input logic        q);
      jk_t g;
      g.j = s & ~q;
      g.k = r & q;
      if (s & r) begin
         case (mode)
            MODE_RST_DOM: g.j = 1'b0;
            MODE_SET_DOM: g.k = 1'b0;
            default: begin
               g.j = 1'b0;
               g.k = 1'b0;
            end
         endcase
      end
      return g;
   endfunction

endpackage : ff_conv_pkg

// File: rtl/jk_ff.sv
// Single-bit JK flip-flop with synchronous active-low reset.
module jk_ff
   import ff_conv_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q,
   output logic q_b
);

   logic q_q;
   logic q_d;

   // Next state from the JK characteristic equation
   always_comb begin
      q_d = jk_next(q_q, j, k);
   end

   // State register, reset to 0
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q   = q_q;
   assign q_b = ~q_q;

endmodule : jk_ff

// File: rtl/jk_to_sr_bank.sv
// Bank of SR flip-flops built from JK cores, with a selectable policy for
// S=R=1 and sticky/counted illegal-input diagnostics.
module jk_to_sr_bank
   import ff_conv_pkg::*;
#(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned ILLEGAL_MODE = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_b,
   output logic             err_flag,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned      EFF_MODE = norm_mode(ILLEGAL_MODE);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   logic [WIDTH-1:0] j_c;
   logic [WIDTH-1:0] k_c;
   logic [WIDTH-1:0] q_w;
   logic [WIDTH-1:0] q_b_w;
   logic             illegal_c;

   logic             err_flag_q;
   logic             err_flag_d;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] err_cnt_d;

   // Per-bit conversion gating from SR requests to JK drive
   always_comb begin
      jk_t gate;
      gate = '0;
      j_c  = '0;
      k_c  = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         gate   = sr_gate(EFF_MODE, s[i], r[i], q_w[i]);
         j_c[i] = gate.j;
         k_c[i] = gate.k;
      end
   end

   // JK cores, one per bank bit
   for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
      jk_ff u_jk_ff (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j_c[gi]),
         .k     (k_c[gi]),
         .q     (q_w[gi]),
         .q_b   (q_b_w[gi])
      );
   end

   assign illegal_c = |(s & r);

   // Diagnostics next state: clear restarts counting without losing this cycle
   always_comb begin
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      if (err_clr) begin
         err_flag_d = illegal_c;
         err_cnt_d  = illegal_c ? CNT_W'(1) : '0;
      end else if (illegal_c) begin
         err_flag_d = 1'b1;
         if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
      end
   end

   // Diagnostics registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign q        = q_w;
   assign q_b      = q_b_w;
   assign err_flag = err_flag_q;
   assign err_cnt  = err_cnt_q;

endmodule : jk_to_sr_bank

// File: doc/jk_to_sr_bank.md
# jk_to_sr_bank

Parameterised bank of SR flip-flops, each built from a JK flip-flop core through conversion gating. It is the reverse of the team's SR-to-JK conversion. The block adds a defined per-bank policy for the forbidden S=R=1 input, plus sticky and counted illegal-input diagnostics. It sits alongside the other flip-flop conversion blocks as a reusable state-holding primitive and as a verification vehicle for them.

## Interface
Parameters:
- `WIDTH`, default 8: number of SR bits in the bank.
- `CNT_W`, default 8: width of the illegal-event counter.
- `ILLEGAL_MODE`, default 0: policy when S=R=1 on a bit. 0 = hold, 1 = reset-dominant, 2 = set-dominant. Any other value behaves as 0.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `s`  in  WIDTH: per-bit set request.
- `r`  in  WIDTH: per-bit reset request.
- `err_clr`  in  1: clears `err_flag` and `err_cnt`.
- `q`  out  WIDTH: flip-flop state.
- `q_b`  out  WIDTH: always the bitwise complement of `q`.
- `err_flag`  out  1: sticky; set once any S=R=1 is sampled.
- `err_cnt`  out  CNT_W: saturating count of cycles with at least one illegal bit.

## Operation
- Each bit i is a JK flip-flop with the standard JK next-state:
  - J=0, K=0: hold.
  - J=0, K=1: 0.
  - J=1, K=0: 1.
  - J=1, K=1: toggle.
- Conversion gating for each bit:
  - Base equations: J = s[i]·~q[i], K = r[i]·q[i].
  - When s[i]=r[i]=1, the base equations would toggle. The policy gating below replaces that case.
  - Mode 0 (hold): J = s·~r·~q, K = r·~s·q.
  - Mode 1 (reset-dominant): J = s·~r·~q, K = r·q.
  - Mode 2 (set-dominant): J = s·~q, K = r·~s·q.
- Resulting SR behaviour, with J=K=1 never presented to the core:
  - s=0, r=0: hold.
  - s=1, r=0: q becomes 1.
  - s=0, r=1: q becomes 0.
  - s=1, r=1: hold, 0 or 1, according to the mode.
- Illegal detect: `illegal = |(s & r)`, evaluated every cycle.
- Diagnostics update, in priority order:
  - If `err_clr` = 1, the counter restarts: `err_cnt` = `illegal` ? 1 : 0 and `err_flag` = `illegal`. A same-cycle illegal event is never lost.
  - Otherwise, if `illegal` = 1: `err_flag` becomes 1 and `err_cnt` increments, saturating at 2^CNT_W−1 with no wrap.
  - Otherwise both hold.
- One illegal cycle counts once, regardless of how many bits are illegal.

## Timing
- Latency is one cycle: inputs sampled at edge n appear on `q`, `q_b`, `err_flag` and `err_cnt` after edge n.
- There is no combinational path from any input to any output.
- Reset values (when `rst_n`=0 at an edge): `q` = 0, `q_b` = all ones, `err_flag` = 0, `err_cnt` = 0.
- Reset overrides `s`, `r` and `err_clr` in the same cycle.
- Reset asserted mid-operation clears everything at the next edge. `q` remains 0 while `s`=0 after release.
- First edge after `rst_n` returns to 1: normal operation. A pending `s` takes effect at that edge.
- Saturation: at `err_cnt` = max, a further illegal cycle keeps max. If `err_clr` coincides with saturation, the next value is 0 or 1 per the clear rule.

## Structure
- Shared package `ff_conv_pkg`:
  - Mode constants `MODE_HOLD`=0, `MODE_RST_DOM`=1, `MODE_SET_DOM`=2.
  - Function for JK next-state.
- Sub-module `jk_ff`: single-bit JK core with `clk`, `rst_n`, j, k, q and q_b. Instantiated WIDTH times through a generate loop.
- The top level holds the gating logic and the diagnostics counter.

## Test plan
- Reset (rst_n=0 for 2 cycles, s=0xFF) → q=0x00, q_b=0xFF, err_cnt=0, err_flag=0. After release, q=0xFF one edge later.
- Basic SR with WIDTH=8: s=0x0F, r=0 → q=0x0F. Then s=0, r=0x03 → q=0x0C. Then s=r=0 for 3 cycles → q stays 0x0C.
- Illegal policy, one configuration per mode:
  - Set-up: q=0x0C, then s=r=0x0F for 4 cycles.
  - Mode 0 → q stays 0x0C (no toggling).
  - Mode 1 → q=0x00.
  - Mode 2 → q=0x0F.
  - All modes → err_flag=1 and err_cnt=4.
- Saturation with CNT_W=2: 5 consecutive illegal cycles → err_cnt=3 and holds at 3.
- Clear collision: err_cnt=3, then err_clr=1 with s=r=0x01 in the same cycle → err_cnt=1, err_flag=1. Next cycle err_clr=1 with no illegal → err_cnt=0, err_flag=0.
- Reset mid-operation: q=0xAA, err_cnt=2, then rst_n=0 for one edge while s=0x55 → q=0x00, err_cnt=0. On the following edge, with rst_n=1 and s=0x55 → q=0x55.
